// File: rtl/dz_pkg.sv
// rtl/dz_pkg.sv - shared constants, glyph table and scan state type for the dot-matrix scanner
package dz_pkg;

    localparam logic [1:0] COLOR_OFF  = 2'b00;
    localparam logic [1:0] COLOR_RED  = 2'b01;
    localparam logic [1:0] COLOR_GRN  = 2'b10;
    localparam logic [1:0] COLOR_BOTH = 2'b11;

    localparam logic [7:0] ROW_IDLE    = 8'hFF;
    localparam logic [3:0] DIGIT_BLANK = 4'hF;

    // Row 0 is the top row; bit 7 is the leftmost column.
    localparam logic [7:0] GLYPH_TBL [0:9][0:7] = '{
        '{8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h3C, 8'h00},
        '{8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00},
        '{8'h3C, 8'h66, 8'h06, 8'h0C, 8'h30, 8'h60, 8'h7E, 8'h00},
        '{8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C, 8'h00},
        '{8'h0C, 8'h1C, 8'h3C, 8'h6C, 8'h7E, 8'h0C, 8'h0C, 8'h00},
        '{8'h7E, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h66, 8'h3C, 8'h00},
        '{8'h3C, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h00},
        '{8'h7E, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h30, 8'h30, 8'h00},
        '{8'h3C, 8'h66, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h3C, 8'h00},
        '{8'h3C, 8'h66, 8'h66, 8'h3E, 8'h06, 8'h0C, 8'h38, 8'h00}
    };

    typedef enum logic {
        BLANK,
        DRIVE
    } dz_state_e;

endpackage

// File: rtl/dz_glyph_rom.sv
// rtl/dz_glyph_rom.sv - combinational digit/row to column-pattern lookup, dark for non-digits
module dz_glyph_rom
    import dz_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic [2:0] row_idx_i,
    output logic [7:0] pattern_o
);

    always_comb begin
        pattern_o = 8'h00;
        if (digit_i <= 4'd9) begin
            pattern_o = GLYPH_TBL[digit_i][row_idx_i];
        end
    end

endmodule

// File: rtl/dz_scan_ctrl.sv
// rtl/dz_scan_ctrl.sv - row-scan scheduler with per-slot blanking and frame-aligned digit swap
// Optional blinking of digit 0 is compiled in with DZ_BLINK_EN.
module dz_scan_ctrl
    import dz_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 125,
    parameter int unsigned BLANK_CYC    = 4,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] digit_i,
    input  logic       digit_vld_i,
    input  logic [1:0] color_i,
    output logic [7:0] row_o,
    output logic [7:0] colr_o,
    output logic [7:0] colg_o,
    output logic       frame_start_o
);

    localparam int unsigned   SW              = $clog2(SCAN_DIV);
    localparam logic [SW-1:0] SLOT_LAST       = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] SLOT_BLANK_LAST = SW'(BLANK_CYC - 1);

    logic [SW-1:0] slot_q, slot_d;
    logic [2:0]    row_idx_q, row_idx_d;
    dz_state_e     state_q, state_d;
    logic [3:0]    pending_q, pending_d;
    logic [3:0]    disp_q, disp_d;
    logic [7:0]    row_q, row_d;
    logic [7:0]    colr_q, colr_d;
    logic [7:0]    colg_q, colg_d;
    logic          frame_start_q, frame_start_d;
    logic          slot_end;
    logic          frame_end;
    logic          red_en;
    logic          grn_en;
    logic          blink_dark;
    logic [7:0]    glyph;

    dz_glyph_rom u_glyph_rom (
        .digit_i   (disp_q),
        .row_idx_i (row_idx_q),
        .pattern_o (glyph)
    );

    always_comb begin
        slot_end  = (slot_q == SLOT_LAST);
        frame_end = slot_end && (row_idx_q == 3'd7);
        slot_d    = slot_end ? '0 : slot_q + 1'b1;
        row_idx_d = slot_end ? row_idx_q + 3'd1 : row_idx_q;

        state_d = state_q;
        case (state_q)
            BLANK:   if (slot_q == SLOT_BLANK_LAST) state_d = DRIVE;
            DRIVE:   if (slot_end) state_d = BLANK;
            default: state_d = BLANK;
        endcase

        // A strobe landing exactly on the boundary bypasses pending so it is not lost for a frame.
        pending_d = digit_vld_i ? digit_i : pending_q;
        disp_d    = disp_q;
        if (frame_end) begin
            disp_d = digit_vld_i ? digit_i : pending_q;
        end

        red_en = (color_i == COLOR_RED) || (color_i == COLOR_BOTH);
        grn_en = (color_i == COLOR_GRN) || (color_i == COLOR_BOTH);

        row_d         = ROW_IDLE;
        colr_d        = 8'h00;
        colg_d        = 8'h00;
        frame_start_d = frame_end;
        if (state_q == DRIVE) begin
            row_d = ~(8'b1 << row_idx_q);
            if (color_i != COLOR_OFF && !blink_dark) begin
                colr_d = red_en ? glyph : 8'h00;
                colg_d = grn_en ? glyph : 8'h00;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_q        <= '0;
            row_idx_q     <= 3'd0;
            state_q       <= BLANK;
            pending_q     <= DIGIT_BLANK;
            disp_q        <= DIGIT_BLANK;
            row_q         <= ROW_IDLE;
            colr_q        <= 8'h00;
            colg_q        <= 8'h00;
            frame_start_q <= 1'b0;
        end else begin
            slot_q        <= slot_d;
            row_idx_q     <= row_idx_d;
            state_q       <= state_d;
            pending_q     <= pending_d;
            disp_q        <= disp_d;
            row_q         <= row_d;
            colr_q        <= colr_d;
            colg_q        <= colg_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef DZ_BLINK_EN
    localparam int unsigned   BW         = $clog2(2 * BLINK_FRAMES);
    localparam logic [BW-1:0] BLINK_LAST = BW'(2 * BLINK_FRAMES - 1);
    localparam logic [BW-1:0] BLINK_HALF = BW'(BLINK_FRAMES);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;

    // Restarting on every digit change makes a freshly shown 0 always begin in its lit half.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        if (disp_d != disp_q) begin
            blink_cnt_d = '0;
        end else if (frame_end) begin
            blink_cnt_d = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            blink_cnt_q <= '0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
        end
    end

    assign blink_dark = (disp_q == 4'd0) && (blink_cnt_q >= BLINK_HALF);
`else
    // BLINK_FRAMES only matters when blinking is compiled in.
    if (BLINK_FRAMES < 1) begin : g_blink_frames_unused
    end

    assign blink_dark = 1'b0;
`endif

    assign row_o         = row_q;
    assign colr_o        = colr_q;
    assign colg_o        = colg_q;
    assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_dz_scan_ctrl.sv
// tb/tb_dz_scan_ctrl.sv - directed self-checking bench for dz_scan_ctrl (SCAN_DIV=8, BLANK_CYC=2)
module tb_dz_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] digit = 4'hF;
    logic       digit_vld = 1'b0;
    logic [1:0] color = 2'b01;
    logic [7:0] row;
    logic [7:0] colr;
    logic [7:0] colg;
    logic       frame_start;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] g0 [0:7] = '{8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h3C, 8'h00};
    logic [7:0] g1 [0:7] = '{8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00};
    logic [7:0] g3 [0:7] = '{8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C, 8'h00};
    logic [7:0] g8 [0:7] = '{8'h3C, 8'h66, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h3C, 8'h00};

    always #5 clk = ~clk;

    dz_scan_ctrl #(
        .SCAN_DIV     (8),
        .BLANK_CYC    (2),
        .BLINK_FRAMES (2)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .digit_i       (digit),
        .digit_vld_i   (digit_vld),
        .color_i       (color),
        .row_o         (row),
        .colr_o        (colr),
        .colg_o        (colg),
        .frame_start_o (frame_start)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic goto(input int k);
        while (cyc < k) step();
    endtask

    task automatic pulse(input logic [3:0] d);
        digit     = d;
        digit_vld = 1'b1;
        step();
        digit_vld = 1'b0;
    endtask

    task automatic pins(input string tag, input logic [7:0] r, input logic [7:0] cr, input logic [7:0] cg);
        chk({tag, "_row"}, row, r);
        chk({tag, "_colr"}, colr, cr);
        chk({tag, "_colg"}, colg, cg);
    endtask

    initial begin
        logic [7:0] lit;

        // 1: reset values, then first driven row three edges after release
        repeat (3) @(negedge clk);
        pins("rst_hold", 8'hFF, 8'h00, 8'h00);
        chk("rst_fs", {7'd0, frame_start}, 8'h00);
        rst = 1'b0;
        cyc = 0;
        digit     = 4'd8;
        digit_vld = 1'b1;
        step();
        digit_vld = 1'b0;
        chk("rel_k1_row", row, 8'hFF);
        goto(2);
        chk("rel_k2_row", row, 8'hFF);
        goto(3);
        pins("rel_k3", 8'hFE, 8'h00, 8'h00);

        // 2: full frame of digit 8, red only
        goto(63);
        chk("fs_k63", {7'd0, frame_start}, 8'h00);
        goto(64);
        chk("fs_k64", {7'd0, frame_start}, 8'h01);
        for (int r = 0; r < 8; r++) begin
            goto(64 + 8 * r + 1);
            pins("f1_blank0", 8'hFF, 8'h00, 8'h00);
            if (r == 0) chk("fs_k65", {7'd0, frame_start}, 8'h00);
            goto(64 + 8 * r + 2);
            pins("f1_blank1", 8'hFF, 8'h00, 8'h00);
            goto(64 + 8 * r + 3);
            pins("f1_drive_first", ~(8'h01 << r), g8[r], 8'h00);
            goto(64 + 8 * r + 8);
            pins("f1_drive_last", ~(8'h01 << r), g8[r], 8'h00);
        end
        chk("fs_k128", {7'd0, frame_start}, 8'h01);

        // 3a: swap to 3 at the next boundary; strobe 1 mid-frame takes effect a frame later
        pulse(4'd3);
        goto(155);
        pins("f2_row3_still8", 8'hF7, g8[3], 8'h00);
        goto(195);
        pins("f3_row0_is3", 8'hFE, g3[0], 8'h00);
        goto(218);
        pulse(4'd1);
        pins("f3_row3_is3", 8'hF7, g3[3], 8'h00);
        goto(236);
        pins("f3_row5_is3", 8'hDF, g3[5], 8'h00);
        goto(243);
        pins("f3_row6_is3", 8'hBF, g3[6], 8'h00);
        goto(259);
        pins("f4_row0_is1", 8'hFE, g1[0], 8'h00);

        // 3b: strobe in the boundary cycle bypasses pending
        goto(270);
        pulse(4'd3);
        goto(323);
        pins("f5_row0_is3", 8'hFE, g3[0], 8'h00);
        goto(383);
        pulse(4'd1);
        goto(387);
        pins("f6_row0_bypass1", 8'hFE, g1[0], 8'h00);
        goto(395);
        pins("f6_row1_bypass1", 8'hFD, g1[1], 8'h00);

        // last strobe before a boundary wins
        goto(400);
        pulse(4'd8);
        goto(410);
        pulse(4'd3);
        goto(475);
        pins("f7_row3_last_wins", 8'hF7, g3[3], 8'h00);

        // 4: colour selects, sampled every cycle
        goto(480);
        color = 2'b11;
        goto(483);
        pins("color_both", 8'hEF, g3[4], g3[4]);
        goto(490);
        color = 2'b00;
        goto(491);
        pins("color_off", 8'hDF, 8'h00, 8'h00);
        goto(498);
        color = 2'b10;
        goto(499);
        pins("color_grn", 8'hBF, 8'h00, g3[6]);
        goto(500);
        color = 2'b01;
        pulse(4'hA);
        goto(515);
        pins("digit_A_row0", 8'hFE, 8'h00, 8'h00);
        goto(539);
        pins("digit_A_row3", 8'hF7, 8'h00, 8'h00);

        // 5: asynchronous reset mid-drive
        goto(540);
        pulse(4'd8);
        goto(589);
        pins("pre_rst_drive", 8'hFD, g8[1], 8'h00);
        #2 rst = 1'b1;
        #1;
        pins("async_rst", 8'hFF, 8'h00, 8'h00);
        chk("async_rst_fs", {7'd0, frame_start}, 8'h00);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        goto(3);
        pins("rst2_k3", 8'hFE, 8'h00, 8'h00);
        goto(64);
        chk("rst2_fs_k64", {7'd0, frame_start}, 8'h01);
        goto(67);
        pins("rst2_pending_blank", 8'hFE, 8'h00, 8'h00);

        // 6: digit 0 blinking (two frames lit, two dark) or steady
        goto(70);
        pulse(4'd0);
        for (int f = 2; f < 8; f++) begin
            lit = g0[0];
`ifdef DZ_BLINK_EN
            if (f == 4 || f == 5) lit = 8'h00;
`endif
            goto(64 * f + 3);
            pins("blink_row0", 8'hFE, lit, 8'h00);
            if (f == 4) begin
                lit = g0[3];
`ifdef DZ_BLINK_EN
                lit = 8'h00;
`endif
                goto(285);
                pins("blink_row3", 8'hF7, lit, 8'h00);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
